// File: rtl/game_pkg.sv
// Shared definitions for frame-rate animation blocks.
package game_pkg;

  // Default width of a signed sprite screen offset
  localparam int unsigned OFFSET_W = 12;

  // Flight state of a trajectory generator
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

endpackage : game_pkg

// File: rtl/spawn_path_if.sv
// Launch request and sprite offset bundle of one trajectory generator.
interface spawn_path_if #(
  parameter int unsigned HWIDTH = game_pkg::OFFSET_W,
  parameter int unsigned VWIDTH = game_pkg::OFFSET_W
);

  logic              en;
  logic [HWIDTH-1:0] hoffset;
  logic [VWIDTH-1:0] voffset;
  logic              active;

  // Launcher side: issues en, consumes the offsets
  modport master (
    output en,
    input  hoffset,
    input  voffset,
    input  active
  );

  // Generator side: takes en, drives the offsets
  modport slave (
    input  en,
    output hoffset,
    output voffset,
    output active
  );

endinterface : spawn_path_if

// File: rtl/path_lerp.sv
// Linear interpolation SRC -> DST at step k of STEP, truncating toward zero.
module path_lerp #(
  parameter int unsigned              W    = 12,
  parameter logic signed [W-1:0]      SRC  = '0,
  parameter logic signed [W-1:0]      DST  = '0,
  parameter int unsigned              STEP = 32
) (
  input  logic [$clog2(STEP+1)-1:0] k_i,
  output logic signed [W-1:0]       pos_o
);

  localparam int unsigned KW = $clog2(STEP + 1);
  localparam int unsigned DW = W + 1;
  // k is unsigned, so one extra bit keeps it positive in the signed product
  localparam int unsigned PW = DW + KW + 1;

  localparam logic signed [DW-1:0] DIFF   = DW'(DST) - DW'(SRC);
  localparam logic signed [PW-1:0] STEP_S = PW'(STEP);

  // Signed division truncates toward zero; the final add wraps modulo 2^W
  assign pos_o = SRC + W'((PW'(DIFF) * PW'($signed({1'b0, k_i}))) / STEP_S);

endmodule : path_lerp

// File: rtl/spawn_path.sv
// Sprite trajectory generator: on launch, moves the offset from source to
// destination over STEP ticks (one tick per frame), then returns to idle.
module spawn_path
  import game_pkg::*;
#(
  parameter int unsigned              HWIDTH = OFFSET_W,
  parameter int unsigned              VWIDTH = OFFSET_W,
  parameter logic signed [HWIDTH-1:0] HSRC   = '0,
  parameter logic signed [VWIDTH-1:0] VSRC   = '0,
  parameter logic signed [HWIDTH-1:0] HDST   = '0,
  parameter logic signed [VWIDTH-1:0] VDST   = '0,
  parameter int unsigned              STEP   = 32
) (
  input  logic         clk,
  input  logic         rst,
  spawn_path_if.slave  sp
);

  localparam int unsigned KW = $clog2(STEP + 1);

  run_state_e               state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     active_q;
  logic signed [HWIDTH-1:0] hoff_q, hpos;
  logic signed [VWIDTH-1:0] voff_q, vpos;

  // Positions for the upcoming step; k_d is 0 while idle, which yields the source
  path_lerp #(.W(HWIDTH), .SRC(HSRC), .DST(HDST), .STEP(STEP)) u_hlerp (
    .k_i   (k_d),
    .pos_o (hpos)
  );

  path_lerp #(.W(VWIDTH), .SRC(VSRC), .DST(VDST), .STEP(STEP)) u_vlerp (
    .k_i   (k_d),
    .pos_o (vpos)
  );

  // State, step counter and registered offsets
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      active_q <= 1'b0;
      hoff_q   <= HSRC;
      voff_q   <= VSRC;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      active_q <= (state_d == RUN);
      hoff_q   <= hpos;
      voff_q   <= vpos;
    end
  end

  // Launch while idle, count steps in flight, drop back after the destination step
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (sp.en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (k_q == KW'(STEP)) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign sp.hoffset = hoff_q;
  assign sp.voffset = voff_q;
  assign sp.active  = active_q;

endmodule : spawn_path

// File: tb/tb_spawn_path.sv
// Bench for spawn_path: three parameterisations checked every cycle against a
// formula-level model, plus hand-computed literal points.
module tb_spawn_path;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  spawn_path_if #(.HWIDTH(12), .VWIDTH(12)) if_a ();
  spawn_path_if #(.HWIDTH(12), .VWIDTH(12)) if_b ();
  spawn_path_if #(.HWIDTH(12), .VWIDTH(12)) if_c ();

  spawn_path #(.HWIDTH(12), .VWIDTH(12), .HSRC(-12'sd80), .VSRC(-12'sd140),
               .HDST(-12'sd120), .VDST(12'sd220), .STEP(32)) dut_a (
    .clk (clk), .rst (rst), .sp (if_a.slave));

  spawn_path #(.HWIDTH(12), .VWIDTH(12), .HSRC(12'sd0), .VSRC(-12'sd300),
               .HDST(12'sd0), .VDST(12'sd400), .STEP(32)) dut_b (
    .clk (clk), .rst (rst), .sp (if_b.slave));

  spawn_path #(.HWIDTH(12), .VWIDTH(12), .HSRC(12'sd0), .VSRC(12'sd0),
               .HDST(12'sd100), .VDST(12'sd0), .STEP(1)) dut_c (
    .clk (clk), .rst (rst), .sp (if_c.slave));

  // Model parameters per instance (a, b, c)
  localparam int HS [3] = '{-80, 0, 0};
  localparam int VS [3] = '{-140, -300, 0};
  localparam int HD [3] = '{-120, 0, 100};
  localparam int VD [3] = '{220, 400, 0};
  localparam int ST [3] = '{32, 32, 1};

  // Model flight step per instance; -1 means idle
  int fk [3] = '{-1, -1, -1};

  function automatic logic [11:0] exp_pos(input int src, input int dst, input int st, input int k);
    return 12'(src + ((dst - src) * k) / st);
  endfunction

  function automatic int next_k(input int cur, input logic en, input int st);
    if (cur < 0) return (en === 1'b1) ? 0 : -1;
    if (cur < st) return cur + 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input int i, input logic act,
                     input logic [11:0] h, input logic [11:0] v);
    int kk;
    kk = (fk[i] < 0) ? 0 : fk[i];
    chk({nm, "_active"}, 32'(act), 32'(fk[i] >= 0));
    chk({nm, "_hoffset"}, 32'(h), 32'(exp_pos(HS[i], HD[i], ST[i], kk)));
    chk({nm, "_voffset"}, 32'(v), 32'(exp_pos(VS[i], VD[i], ST[i], kk)));
  endtask

  // Model advance on each tick
  always @(posedge clk) begin
    if (rst) begin
      fk <= '{-1, -1, -1};
    end else begin
      fk[0] <= next_k(fk[0], if_a.en, ST[0]);
      fk[1] <= next_k(fk[1], if_b.en, ST[1]);
      fk[2] <= next_k(fk[2], if_c.en, ST[2]);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a", 0, if_a.active, if_a.hoffset, if_a.voffset);
      cmp("b", 1, if_b.active, if_b.hoffset, if_b.voffset);
      cmp("c", 2, if_c.active, if_c.hoffset, if_c.voffset);
    end
  end

  initial begin
    int n;
    int m;
    if_a.en = 1'b0;
    if_b.en = 1'b0;
    if_c.en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_active", 32'(if_a.active), 32'h0);
    chk("rst_h", 32'(if_a.hoffset), 32'h0FB0);
    chk("rst_v", 32'(if_a.voffset), 32'h0F74);

    // Idle with en low
    repeat (10) begin
      @(negedge clk);
      chk("idle_active", 32'(if_a.active), 32'h0);
      chk("idle_h", 32'(if_a.hoffset), 32'h0FB0);
      chk("idle_v", 32'(if_a.voffset), 32'h0F74);
    end

    // Single pulse flight on instance a
    if_a.en = 1'b1;
    @(negedge clk);
    if_a.en = 1'b0;
    chk("launch_active", 32'(if_a.active), 32'h1);
    n = 0;
    while (if_a.active === 1'b1 && n < 100) begin
      case (n)
        0:  begin chk("k0_h", 32'(if_a.hoffset), 32'h0FB0);  chk("k0_v", 32'(if_a.voffset), 32'h0F74);  end
        1:  begin chk("k1_h", 32'(if_a.hoffset), 32'h0FAF);  chk("k1_v", 32'(if_a.voffset), 32'h0F7F);  end
        16: begin chk("k16_h", 32'(if_a.hoffset), 32'h0F9C); chk("k16_v", 32'(if_a.voffset), 32'h0028); end
        32: begin chk("k32_h", 32'(if_a.hoffset), 32'h0F88); chk("k32_v", 32'(if_a.voffset), 32'h00DC); end
        default: ;
      endcase
      n++;
      @(negedge clk);
    end
    chk("flight_len", 32'(n), 32'd33);
    chk("end_active", 32'(if_a.active), 32'h0);
    chk("end_h", 32'(if_a.hoffset), 32'h0FB0);
    chk("end_v", 32'(if_a.voffset), 32'h0F74);

    // en held high: back-to-back flights with one idle cycle between
    if_a.en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      m = 0;
      while (if_a.active !== 1'b1 && m < 5) begin
        @(negedge clk);
        m++;
      end
      chk("held_gap", 32'(m), 32'd1);
      n = 0;
      while (if_a.active === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("held_len", 32'(n), 32'd33);
    end
    if_a.en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in mid-flight at k=10
    if_a.en = 1'b1;
    @(negedge clk);
    if_a.en = 1'b0;
    repeat (10) @(negedge clk);
    chk("k10_h", 32'(if_a.hoffset), 32'h0FA4);
    chk("k10_v", 32'(if_a.voffset), 32'h0FE4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_active", 32'(if_a.active), 32'h0);
    chk("abort_h", 32'(if_a.hoffset), 32'h0FB0);
    chk("abort_v", 32'(if_a.voffset), 32'h0F74);
    rst = 1'b0;
    if_a.en = 1'b1;
    @(negedge clk);
    if_a.en = 1'b0;
    chk("relaunch_active", 32'(if_a.active), 32'h1);
    chk("relaunch_h", 32'(if_a.hoffset), 32'h0FB0);
    @(negedge clk);
    chk("relaunch_k1_h", 32'(if_a.hoffset), 32'h0FAF);
    chk("relaunch_k1_v", 32'(if_a.voffset), 32'h0F7F);
    n = 0;
    while (if_a.active === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("relaunch_rest", 32'(n), 32'd32);

    // Instance b: constant horizontal, vertical -300 -> 400
    if_b.en = 1'b1;
    @(negedge clk);
    if_b.en = 1'b0;
    n = 0;
    while (if_b.active === 1'b1 && n < 100) begin
      chk("b_hconst", 32'(if_b.hoffset), 32'h0);
      case (n)
        0:  chk("b_k0_v", 32'(if_b.voffset), 32'h0ED4);
        1:  chk("b_k1_v", 32'(if_b.voffset), 32'h0EE9);
        32: chk("b_k32_v", 32'(if_b.voffset), 32'h0190);
        default: ;
      endcase
      n++;
      @(negedge clk);
    end
    chk("b_len", 32'(n), 32'd33);

    // Instance c: STEP=1 gives two active cycles
    if_c.en = 1'b1;
    @(negedge clk);
    if_c.en = 1'b0;
    chk("c_k0_active", 32'(if_c.active), 32'h1);
    chk("c_k0_h", 32'(if_c.hoffset), 32'h0);
    @(negedge clk);
    chk("c_k1_active", 32'(if_c.active), 32'h1);
    chk("c_k1_h", 32'(if_c.hoffset), 32'h064);
    @(negedge clk);
    chk("c_idle_active", 32'(if_c.active), 32'h0);
    chk("c_idle_h", 32'(if_c.hoffset), 32'h0);

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spawn_path
